// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory with req/gnt/rvalid handshake, wait states, byte-enable stores and error reporting.
// Define DMEM_RESPONDER_ALIGN_CHECK_EN to also fault addresses with addr[1:0] != 0.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [3:0] cnt;
  logic we_q;
  logic [31:0] addr_q;
  logic [3:0] be_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic commit, c_we, c_oor, c_err;
  logic [31:0] c_addr, c_wdata;
  logic [3:0] c_be;
  logic [AW-1:0] c_idx;
  assign gnt_o = state == IDLE;
  // With zero wait states the commit happens on the accepting edge, so it must see the live inputs.
  always_comb begin
    state_d = state == IDLE ? (req_i ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    commit = !rst_i && state_d == RESP && state != RESP;
    c_we = state == IDLE ? we_i : we_q;
    c_addr = state == IDLE ? addr_i : addr_q;
    c_be = state == IDLE ? be_i : be_q;
    c_wdata = state == IDLE ? wdata_i : wdata_q;
    c_idx = c_addr[AW+1:2];
    c_oor = {2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS);
  end
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  assign c_err = c_oor | (|c_addr[1:0]);
`else
  logic unused_lsb;
  assign unused_lsb = ^c_addr[1:0];
  assign c_err = c_oor;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 4'd0;
      rvalid_o <= 1'b0;
      rdata_o <= '0;
      err_o <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
    end else begin
      rvalid_o <= commit;
      if (gnt_o && req_i) begin
        we_q <= we_i;
        addr_q <= addr_i;
        be_q <= be_i;
        wdata_q <= wdata_i;
        cnt <= 4'(WAIT_STATES - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_o <= c_err;
        rdata_o <= (c_err || c_we) ? '0 : mem[c_idx];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (commit && c_we && !c_err)
      for (int n = 0; n < 4; n++)
        if (c_be[n]) mem[c_idx][8*n +: 8] <= c_wdata[8*n +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives a 1-wait-state and a 0-wait-state responder, checking both every cycle against a transaction-level model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  logic req [2];
  logic we [2];
  logic [31:0] addr [2];
  logic [3:0] be [2];
  logic [31:0] wdata [2];
  logic gnt [2];
  logic rvalid [2];
  logic [31:0] rdata [2];
  logic err [2];
  int vectors = 0;
  int miscompares = 0;
  int wait_len = 0;
  bit pin_v = 0;
  int pin_d = 0;
  logic [31:0] pin_rdata = '0;
  logic pin_err = 1'b0;
  int cyc = 0;
  int free_e [2] = '{0, 0};
  int commit_e [2] = '{0, 0};
  int resp_e [2] = '{-10, -10};
  bit pend [2] = '{0, 0};
  logic t_we [2];
  logic [31:0] t_addr [2];
  logic [3:0] t_be [2];
  logic [31:0] t_wd [2];
  logic [31:0] m_rdata [2];
  logic m_err [2];
  logic [31:0] mm [2][1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  function automatic int ws(input int d);
    return d == 0 ? 1 : 0;
  endfunction

  // One transaction's effect, from the rules: byte address 0x1000 and above is past the last word.
  task automatic do_commit(input int d, input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
    bit e;
    e = a >= 32'h1000;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    e = e || a[1:0] != 2'b00;
`endif
    resp_e[d] <= cyc;
    m_err[d] <= e;
    m_rdata[d] <= (e || w) ? 32'h0 : mm[d][a[11:2]];
    if (!e && w)
      for (int n = 0; n < 4; n++)
        if (b[n]) mm[d][a[11:2]][8*n +: 8] <= wd[8*n +: 8];
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend[d] <= 0;
        free_e[d] <= cyc + 1;
        m_rdata[d] <= '0;
        m_err[d] <= 1'b0;
      end else if (req[d] && cyc >= free_e[d]) begin
        t_we[d] <= we[d];
        t_addr[d] <= addr[d];
        t_be[d] <= be[d];
        t_wd[d] <= wdata[d];
        commit_e[d] <= cyc + ws(d);
        free_e[d] <= cyc + ws(d) + 2;
        pend[d] <= ws(d) != 0;
        if (ws(d) == 0) do_commit(d, we[d], addr[d], be[d], wdata[d]);
      end else if (pend[d] && cyc == commit_e[d]) begin
        pend[d] <= 0;
        do_commit(d, t_we[d], t_addr[d], t_be[d], t_wd[d]);
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        chk("gnt", d, 32'(gnt[d]), 32'(cyc >= free_e[d]));
        chk("rvalid", d, 32'(rvalid[d]), 32'(resp_e[d] == cyc - 1));
        chk("rdata", d, rdata[d], m_rdata[d]);
        chk("err", d, 32'(err[d]), 32'(m_err[d]));
        if (pin_v && pin_d == d && resp_e[d] == cyc - 1) begin
          chk("pin_rdata", d, m_rdata[d], pin_rdata);
          chk("pin_err", d, 32'(m_err[d]), 32'(pin_err));
        end
      end
      chk("handshake_bound", 0, 32'(wait_len < 60), 32'd1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd,
                      input bit keep, input bit pv, input logic [31:0] pr, input logic pe);
    tick;
    pin_v = pv;
    pin_d = d;
    pin_rdata = pr;
    pin_err = pe;
    req[d] = 1'b1;
    we[d] = w;
    addr[d] = a;
    be[d] = b;
    wdata[d] = wd;
    wait_len = 0;
    while (!gnt[d] && wait_len < 64) begin
      tick;
      wait_len++;
    end
    tick;
    if (!keep) begin
      req[d] = 1'b0;
      we[d] = 1'($urandom);
      addr[d] = $urandom;
      be[d] = 4'($urandom);
      wdata[d] = $urandom;
    end
    wait_len = 0;
    while (!rvalid[d] && wait_len < 64) begin
      tick;
      wait_len++;
    end
    wait_len = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 3))
      0, 1: return 32'($urandom_range(0, 35));
      2: return 32'hFE0 + 32'($urandom_range(0, 31));
      default: return $urandom_range(32'h1000, 32'hFFFF_FFFF);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0;
      we[d] = 1'b0;
      addr[d] = '0;
      be[d] = '0;
      wdata[d] = '0;
    end
    repeat (3) tick;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i <= 8; i++) xact(d, 1'b1, 32'(i * 4), 4'hF, 32'h5A5A_0000 + 32'(i), 0, 0, '0, 1'b0);
      for (int i = 1016; i <= 1023; i++) xact(d, 1'b1, 32'(i * 4), 4'hF, 32'h5A5A_0000 + 32'(i), 0, 0, '0, 1'b0);
    end
    xact(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0);
    xact(0, 1'b1, 32'h10, 4'b0010, 32'h0000_AA00, 0, 1, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, 1, 32'hDEAD_AAEF, 1'b0);
    xact(0, 1'b0, 32'h1000, 4'hF, 32'h0, 0, 1, 32'h0, 1'b1);
    xact(0, 1'b0, 32'hFFC, 4'hF, 32'h0, 0, 1, 32'h5A5A_03FF, 1'b0);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    xact(0, 1'b0, 32'h12, 4'hF, 32'h0, 0, 1, 32'h0, 1'b1);
`else
    xact(0, 1'b0, 32'h12, 4'hF, 32'h0, 0, 1, 32'hDEAD_AAEF, 1'b0);
`endif
    tick;
    pin_v = 0;
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 32'h20;
    be[0] = 4'hF;
    wdata[0] = 32'h1234_5678;
    wait_len = 0;
    while (!gnt[0] && wait_len < 64) begin
      tick;
      wait_len++;
    end
    wait_len = 0;
    tick;
    req[0] = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    xact(0, 1'b0, 32'h20, 4'hF, 32'h0, 0, 1, 32'h5A5A_0008, 1'b0);
    tick;
    rst = 1'b1;
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[1] = 32'h20;
    be[1] = 4'hF;
    wdata[1] = 32'hFFFF_FFFF;
    tick;
    req[1] = 1'b0;
    rst = 1'b0;
    xact(1, 1'b0, 32'h20, 4'hF, 32'h0, 0, 1, 32'h5A5A_0008, 1'b0);
    for (int i = 0; i < 8; i++)
      xact(1, 1'($urandom), rnd_addr(), 4'($urandom), $urandom, 1, 0, '0, 1'b0);
    tick;
    req[1] = 1'b0;
    for (int i = 0; i < 300; i++)
      xact(int'($urandom_range(0, 1)), 1'($urandom), rnd_addr(), 4'($urandom), $urandom,
           1'($urandom), 0, '0, 1'b0);
    tick;
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (4) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
